// File: rtl/decode_dispatch_queue_if.sv
// decode_dispatch_queue_if: decode push bundle, dispatch head bundle and status between decode, queue and dispatch
// master: drives enable/flush/ready and the decoded fields, observes the head entry and status
// slave: the queue itself
interface decode_dispatch_queue_if #(
  parameter int addressWidth = 64,
  parameter int opcodeSize = 12,
  parameter int funcUnitCodeSize = 3,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth = 7,
  parameter int PidSize = 20,
  parameter int TidSize = 16,
  parameter int regAccessPatternSize = 2,
  parameter int bodyWidth = 84,
  parameter int formatWidth = 25,
  parameter int depth = 4
);
  localparam int CW = $clog2(depth + 1);
  logic enable_i;
  logic [formatWidth-1:0] instFormat_i;
  logic [opcodeSize-1:0] opcode_i;
  logic [addressWidth-1:0] address_i;
  logic [funcUnitCodeSize-1:0] funcUnitType_i;
  logic [instructionCounterWidth-1:0] majID_i;
  logic [instMinIdWidth-1:0] minID_i;
  logic is64Bit_i;
  logic [PidSize-1:0] pid_i;
  logic [TidSize-1:0] tid_i;
  logic [regAccessPatternSize-1:0] op1rw_i, op2rw_i, op3rw_i, op4rw_i;
  logic op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i;
  logic [bodyWidth-1:0] body_i;
  logic flush_i;
  logic ready_i;
  logic valid_o;
  logic [formatWidth-1:0] instFormat_o;
  logic [opcodeSize-1:0] opcode_o;
  logic [addressWidth-1:0] address_o;
  logic [funcUnitCodeSize-1:0] funcUnitType_o;
  logic [instructionCounterWidth-1:0] majID_o;
  logic [instMinIdWidth-1:0] minID_o;
  logic is64Bit_o;
  logic [PidSize-1:0] pid_o;
  logic [TidSize-1:0] tid_o;
  logic [regAccessPatternSize-1:0] op1rw_o, op2rw_o, op3rw_o, op4rw_o;
  logic op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;
  logic [bodyWidth-1:0] body_o;
  logic [CW-1:0] count_o;
  logic stall_o;
  logic overflow_o;
  modport slave (
    input enable_i, instFormat_i, opcode_i, address_i, funcUnitType_i, majID_i, minID_i, is64Bit_i,
          pid_i, tid_i, op1rw_i, op2rw_i, op3rw_i, op4rw_i, op1IsReg_i, op2IsReg_i, op3IsReg_i,
          op4IsReg_i, body_i, flush_i, ready_i,
    output valid_o, instFormat_o, opcode_o, address_o, funcUnitType_o, majID_o, minID_o, is64Bit_o,
           pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o, op1IsReg_o, op2IsReg_o, op3IsReg_o,
           op4IsReg_o, body_o, count_o, stall_o, overflow_o
  );
  modport master (
    output enable_i, instFormat_i, opcode_i, address_i, funcUnitType_i, majID_i, minID_i, is64Bit_i,
           pid_i, tid_i, op1rw_i, op2rw_i, op3rw_i, op4rw_i, op1IsReg_i, op2IsReg_i, op3IsReg_i,
           op4IsReg_i, body_i, flush_i, ready_i,
    input valid_o, instFormat_o, opcode_o, address_o, funcUnitType_o, majID_o, minID_o, is64Bit_o,
          pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o, op4rw_o, op1IsReg_o, op2IsReg_o, op3IsReg_o,
          op4IsReg_o, body_o, count_o, stall_o, overflow_o
  );
endinterface

// File: rtl/decode_dispatch_queue.sv
// decode_dispatch_queue: in-order FIFO between the strobe-only decode mux and the valid/ready dispatch stage
// clock_i/reset_i: single clock, synchronous active-high reset
// dq (slave): push strobe + decoded fields in, head entry + valid out, ready/flush in, count/stall/overflow out
module decode_dispatch_queue #(
  parameter int addressWidth = 64,
  parameter int opcodeSize = 12,
  parameter int funcUnitCodeSize = 3,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth = 7,
  parameter int PidSize = 20,
  parameter int TidSize = 16,
  parameter int regAccessPatternSize = 2,
  parameter int bodyWidth = 84,
  parameter int formatWidth = 25,
  parameter int depth = 4,
  parameter int stallSlack = 2
) (
  input logic clock_i,
  input logic reset_i,
  decode_dispatch_queue_if.slave dq
);
  localparam int W = formatWidth + opcodeSize + addressWidth + funcUnitCodeSize + instructionCounterWidth
                   + instMinIdWidth + 1 + PidSize + TidSize + 4 * regAccessPatternSize + 4 + bodyWidth;
  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);
  logic [W-1:0] r_mem [depth];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic r_ovf;
  logic w_valid, w_pop, w_push;
  logic [W-1:0] w_din, w_dout;
  assign w_valid = r_count != '0;
  assign w_pop = w_valid & dq.ready_i;
  // a full queue still accepts a push when the head leaves in the same cycle
  assign w_push = dq.enable_i & ((r_count != CW'(depth)) | w_pop);
  assign w_din = {dq.instFormat_i, dq.opcode_i, dq.address_i, dq.funcUnitType_i, dq.majID_i, dq.minID_i,
                  dq.is64Bit_i, dq.pid_i, dq.tid_i, dq.op1rw_i, dq.op2rw_i, dq.op3rw_i, dq.op4rw_i,
                  dq.op1IsReg_i, dq.op2IsReg_i, dq.op3IsReg_i, dq.op4IsReg_i, dq.body_i};
  assign w_dout = w_valid ? r_mem[r_rd] : '0;
  assign {dq.instFormat_o, dq.opcode_o, dq.address_o, dq.funcUnitType_o, dq.majID_o, dq.minID_o,
          dq.is64Bit_o, dq.pid_o, dq.tid_o, dq.op1rw_o, dq.op2rw_o, dq.op3rw_o, dq.op4rw_o,
          dq.op1IsReg_o, dq.op2IsReg_o, dq.op3IsReg_o, dq.op4IsReg_o, dq.body_o} = w_dout;
  assign dq.valid_o = w_valid;
  assign dq.count_o = r_count;
  assign dq.stall_o = r_count >= CW'(depth - stallSlack);
  assign dq.overflow_o = r_ovf;
  // a write landing during flush/reset is harmless: the pointers are cleared at the same edge
  always_ff @(posedge clock_i)
    if (w_push) r_mem[r_wr] <= w_din;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
      r_ovf <= 1'b0;
    end else if (dq.flush_i) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (dq.enable_i && !w_push) r_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_decode_dispatch_queue.sv
// tb_decode_dispatch_queue: randomized + directed scoreboard bench for decode_dispatch_queue
module tb_decode_dispatch_queue;
  localparam int DEPTH = 4;
  localparam int SLACK = 2;
  typedef struct packed {
    logic [24:0] fmt;
    logic [11:0] opc;
    logic [63:0] addr;
    logic [2:0] fu;
    logic [63:0] maj;
    logic [6:0] mnr;
    logic b64;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [1:0] rw1, rw2, rw3, rw4;
    logic r1, r2, r3, r4;
    logic [83:0] body;
  } ent_t;
  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  decode_dispatch_queue_if bus();
  decode_dispatch_queue #(.depth(DEPTH), .stallSlack(SLACK)) dut (.clock_i(clock_i), .reset_i(reset_i), .dq(bus));
  always #5 clock_i = ~clock_i;
  ent_t exp_q[$];
  int m_cnt = 0;
  logic m_ovf = 1'b0;
  bit go = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  ent_t w_out;
  assign w_out = {bus.instFormat_o, bus.opcode_o, bus.address_o, bus.funcUnitType_o, bus.majID_o, bus.minID_o,
                  bus.is64Bit_o, bus.pid_o, bus.tid_o, bus.op1rw_o, bus.op2rw_o, bus.op3rw_o, bus.op4rw_o,
                  bus.op1IsReg_o, bus.op2IsReg_o, bus.op3IsReg_o, bus.op4IsReg_o, bus.body_o};
  task automatic chk(input string name, input logic [307:0] act, input logic [307:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(negedge clock_i) if (go) begin
    chk("count", 308'(bus.count_o), 308'(m_cnt));
    chk("valid", 308'(bus.valid_o), 308'(m_cnt != 0));
    chk("stall", 308'(bus.stall_o), 308'(m_cnt >= DEPTH - SLACK));
    chk("overflow", 308'(bus.overflow_o), 308'(m_ovf));
    if (m_cnt != 0 && exp_q.size() != 0) begin
      chk("head", w_out, exp_q[0]);
      if (bus.ready_i && !bus.flush_i && !reset_i) void'(exp_q.pop_front());
    end else if (m_cnt == 0) chk("idle_payload", w_out, '0);
  end
  function automatic ent_t rnd_ent();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r[307:0];
  endfunction
  task automatic cyc(input logic en, input logic rdy, input logic fl, input logic rs, input logic [63:0] mid);
    ent_t e;
    bit pop, ok;
    e = rnd_ent();
    e.maj = mid;
    bus.enable_i = en;
    {bus.instFormat_i, bus.opcode_i, bus.address_i, bus.funcUnitType_i, bus.majID_i, bus.minID_i,
     bus.is64Bit_i, bus.pid_i, bus.tid_i, bus.op1rw_i, bus.op2rw_i, bus.op3rw_i, bus.op4rw_i,
     bus.op1IsReg_i, bus.op2IsReg_i, bus.op3IsReg_i, bus.op4IsReg_i, bus.body_i} = e;
    bus.ready_i = rdy;
    bus.flush_i = fl;
    reset_i = rs;
    @(posedge clock_i);
    if (rs) begin
      m_cnt = 0;
      m_ovf = 1'b0;
      exp_q.delete();
    end else if (fl) begin
      m_cnt = 0;
      exp_q.delete();
    end else begin
      pop = m_cnt > 0 && rdy;
      ok = en && (m_cnt < DEPTH || pop);
      if (en && !ok) m_ovf = 1'b1;
      if (ok) exp_q.push_back(e);
      m_cnt = m_cnt + int'(ok) - int'(pop);
    end
    #1;
  endtask
  initial begin
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    go = 1'b1;
    for (int i = 1; i <= 3; i++) cyc(1, 0, 0, 0, 64'(i));
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) cyc(1, 0, 0, 0, 64'(i));
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 0, 64'(i));
    cyc(1, 1, 0, 0, 9);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1'(i % 2), 0, 0, 64'(20 + i));
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 30);
    cyc(1, 0, 0, 0, 31);
    cyc(1, 0, 1, 0, 32);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0),
          1'($urandom_range(0, 300) == 0), {$urandom, $urandom});
    cyc(0, 1, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/decode_dispatch_queue.md
# decode_dispatch_queue

Receive-side buffer for the decode pipeline. It captures each decoded instruction the decode multiplexer emits on its single-cycle `enable` strobe and holds it in a FIFO, in program order. It presents the oldest entry to the dispatch stage through a valid/ready handshake. Because the decode multiplexer has no backpressure input, the queue raises an early stall toward fetch/decode and flags any push it is forced to drop.

## Interface
- `addressWidth`, 64, instruction address width
- `opcodeSize`, 12, decoded opcode width
- `funcUnitCodeSize`, 3, functional unit code width
- `instructionCounterWidth`, 64, major ID width
- `instMinIdWidth`, 7, minor ID width
- `PidSize`, 20, process ID width
- `TidSize`, 16, thread ID width
- `regAccessPatternSize`, 2, per-operand access flags width
- `bodyWidth`, 84, operand body width (4 regs + 64b imm)
- `formatWidth`, 25, one-hot instruction format width
- `depth`, 4, entries; power of two, ≥ 2
- `stallSlack`, 2, free entries reserved for in-flight decode; 1 ≤ stallSlack < depth
- `clock_i` in 1: the only clock; all state changes on its rising edge
- `reset_i` in 1: synchronous, active-high
- `enable_i` in 1: push strobe from decode mux
- `instFormat_i` in formatWidth
- `opcode_i` in opcodeSize
- `address_i` in addressWidth
- `funcUnitType_i` in funcUnitCodeSize
- `majID_i` in instructionCounterWidth
- `minID_i` in instMinIdWidth
- `is64Bit_i` in 1
- `pid_i` in PidSize
- `tid_i` in TidSize
- `op1rw_i`..`op4rw_i` in regAccessPatternSize each
- `op1IsReg_i`..`op4IsReg_i` in 1 each
- `body_i` in bodyWidth
- `flush_i` in 1: discard all entries (mispredict/exception)
- `ready_i` in 1: dispatch accepts head entry
- `valid_o` out 1: head entry present
- `instFormat_o` … `body_o` out: head entry fields, with the same widths and order as the inputs
- `count_o` out clog2(depth+1): occupancy
- `stall_o` out 1: upstream must stop issuing new fetches
- `overflow_o` out 1: sticky dropped-push flag

## Operation
- Storage: `depth` entries of the full field bundle (308 bits at defaults); write pointer, read pointer and count are registers. Pointers wrap modulo `depth`.
- Push: `enable_i`=1 and (count < depth, or a pop occurs in the same cycle). The bundle is written at the write pointer and the write pointer advances.
- Pop: `valid_o`=1 and `ready_i`=1. The read pointer advances.
- Count update: count += push − pop.
- Full with push and pop in the same cycle: both occur and count stays at `depth`.
- Empty with push in a cycle: no pop occurs (`valid_o`=0). `ready_i` is ignored while `valid_o`=0.
- Dropped push: `enable_i`=1, count = depth, no pop. The entry is discarded, nothing else changes, and `overflow_o` is set.
- `overflow_o` stays set until reset. Flush does not clear it.
- Flush: `flush_i`=1 sets both pointers and count to 0. Any push or pop in that cycle is ignored.
- Priority: reset > flush > push/pop.
- `valid_o` = (count ≠ 0), decoded combinationally from the count register.
- Payload outputs come combinationally from the entry at the read pointer. All payload outputs are forced to 0 while `valid_o`=0.
- `stall_o` = (count ≥ depth − stallSlack), decoded combinationally from the count register.
- Entries are never reordered. Fields are passed through unmodified.

## Timing
- Reset: `valid_o`=0, `count_o`=0, `stall_o`=0, `overflow_o`=0, all payload outputs 0, both pointers 0.
- Push latency is 1 cycle. An entry pushed at edge N appears on the outputs, with `valid_o`=1, after edge N if the queue was empty.
- Pop takes effect at the edge where `valid_o`&`ready_i`=1. The next entry is visible immediately after that edge.
- Sustained throughput is one push and one pop per cycle.
- `stall_o` reflects count after each edge. Upstream has `stallSlack` cycles of in-flight pushes that are guaranteed to be absorbed.
- Reset or flush asserted mid-stream takes effect at that edge. `valid_o` is 0 in the following cycle.

## Test plan
- Reset, then push majID 1,2,3 with `ready_i`=0 → `count_o`=3, `valid_o`=1, `majID_o`=1, `stall_o`=1 (3 ≥ 2).
- With 3 entries, raise `ready_i` for 3 cycles with no push → `majID_o` sequence 1,2,3, then `valid_o`=0, `count_o`=0, payload 0, `stall_o`=0.
- Fill to 4 entries, then push majID 5 with `ready_i`=0 → entry dropped, `overflow_o`=1, `count_o`=4. A later drain yields 1..4 only, and `overflow_o` stays 1.
- Full queue, push majID 9 with `ready_i`=1 → `count_o` stays 4 and the head advances. After a full drain, 9 is the last entry out.
- Push 6 entries across wrap-around while popping every other cycle → output order matches input order, and `body_o` and `address_o` are bit-exact.
- Two entries queued, `flush_i`=1 together with `enable_i`=1 → next cycle `count_o`=0 and `valid_o`=0. `reset_i` then clears `overflow_o`.
